// File: rtl/test_pattern_checker_if.sv
// Serial-stream and status signals of the test pattern checker.
// The checker side uses the slave modport; the stimulus side uses the master modport.
interface test_pattern_checker_if;
  logic        bit_in;
  logic        bit_valid;
  logic        clr_err;
  logic        locked;
  logic [1:0]  state;
  logic [4:0]  bit_phase;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        lock_lost;

  modport master (
    output bit_in, bit_valid, clr_err,
    input  locked, state, bit_phase, err_pulse, err_count, lock_lost
  );

  modport slave (
    input  bit_in, bit_valid, clr_err,
    output locked, state, bit_phase, err_pulse, err_count, lock_lost
  );
endinterface

// File: rtl/test_pattern_checker.sv
// Locks onto a repeating 32-bit pattern sent LSB-first and then counts bit errors.
// Lock is lost when BAD_LIMIT errors land inside a single pattern word.
module test_pattern_checker #(
  parameter logic [31:0] PATTERN    = 32'hAA550FF0,
  parameter int unsigned GOOD_WORDS = 4,
  parameter int unsigned BAD_LIMIT  = 8
) (
  input logic                   clk,
  input logic                   aresetn,
  test_pattern_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] GOOD_N = 4'(GOOD_WORDS);
  localparam logic [5:0] BAD_N  = 6'(BAD_LIMIT);

  state_t      st;
  logic [31:0] sh;
  logic [5:0]  fill;
  logic [4:0]  phase;
  logic [3:0]  good;
  logic [5:0]  word_err;
  logic [15:0] err_count;
  logic        locked_q;
  logic        err_pulse_q;
  logic        lock_lost_q;

  logic [31:0] sh_nx;
  logic [5:0]  fill_nx;
  logic [5:0]  word_err_nx;
  logic [3:0]  good_nx;
  logic        miss;
  logic        word_end;

  always_comb begin
    sh_nx       = {bus.bit_in, sh[31:1]};
    fill_nx     = (fill == 6'd32) ? fill : fill + 6'd1;
    miss        = bus.bit_in != PATTERN[phase];
    word_end    = phase == 5'd31;
    word_err_nx = word_err + {5'd0, miss};
    good_nx     = good + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      st          <= HUNT;
      sh          <= '0;
      fill        <= '0;
      phase       <= '0;
      good        <= '0;
      word_err    <= '0;
      err_count   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      // A LOCKED mismatch below overrides this clear with a count of one.
      if (bus.clr_err) err_count <= '0;
      if (bus.bit_valid) begin
        sh   <= sh_nx;
        fill <= fill_nx;
      end
      case (st)
        HUNT: begin
          phase <= '0;
          if (bus.bit_valid && fill_nx == 6'd32 && sh_nx == PATTERN) begin
            st   <= VERIFY;
            good <= '0;
          end
        end
        VERIFY: if (bus.bit_valid) begin
          if (miss) begin
            st    <= HUNT;
            fill  <= '0;
            phase <= '0;
          end else begin
            phase <= phase + 5'd1;
            if (word_end) begin
              good <= good_nx;
              if (good_nx == GOOD_N) begin
                st       <= LOCKED;
                locked_q <= 1'b1;
                word_err <= '0;
              end
            end
          end
        end
        LOCKED: if (bus.bit_valid) begin
          if (miss) begin
            err_pulse_q <= 1'b1;
            if (bus.clr_err)             err_count <= 16'd1;
            else if (err_count != '1)    err_count <= err_count + 16'd1;
          end
          if (word_err_nx == BAD_N) begin
            st          <= HUNT;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b1;
            fill        <= '0;
            phase       <= '0;
            word_err    <= '0;
          end else begin
            phase    <= phase + 5'd1;
            word_err <= word_end ? '0 : word_err_nx;
          end
        end
        default: begin
          st       <= HUNT;
          locked_q <= 1'b0;
          fill     <= '0;
          phase    <= '0;
          good     <= '0;
          word_err <= '0;
        end
      endcase
    end
  end

  assign bus.locked    = locked_q;
  assign bus.state     = st;
  assign bus.bit_phase = phase;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count;
  assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_test_pattern_checker.sv
// Self-checking bench for test_pattern_checker: directed scenarios plus a randomized
// stream compared against a queue-based behavioural model of the lock/error rules.
module tb_test_pattern_checker;
  localparam logic [31:0] PAT = 32'hAA550FF0;
  localparam int GW = 4;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  test_pattern_checker_if bus();

  test_pattern_checker #(.PATTERN(PAT), .GOOD_WORDS(GW), .BAD_LIMIT(BL)) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: bits seen since the last HUNT entry live in a queue.
  int m_state, m_phase, m_good, m_werr, m_errc;
  bit m_pulse, m_lost;
  bit hist[$];

  function automatic bit pat_bit(int i);
    logic [31:0] p;
    p = PAT >> (i % 32);
    return p[0];
  endfunction

  function automatic bit hist_is_pattern();
    if (hist.size() != 32) return 1'b0;
    foreach (hist[i]) if (hist[i] != pat_bit(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_phase = 0; m_good = 0; m_werr = 0; m_errc = 0;
    m_pulse = 1'b0; m_lost = 1'b0;
    hist.delete();
  endfunction

  function automatic void model_step(bit b, bit v, bit c);
    bit err = 1'b0;
    m_lost = 1'b0;
    if (v) begin
      hist.push_back(b);
      if (hist.size() > 32) void'(hist.pop_front());
      if (m_state == 0) begin
        if (hist_is_pattern()) begin m_state = 1; m_good = 0; m_phase = 0; end
      end else if (m_state == 1) begin
        if (b != pat_bit(m_phase)) begin
          m_state = 0; m_phase = 0; hist.delete();
        end else begin
          if (m_phase == 31) begin
            m_good++;
            if (m_good == GW) begin m_state = 2; m_werr = 0; end
          end
          m_phase = (m_phase + 1) % 32;
        end
      end else begin
        if (b != pat_bit(m_phase)) begin err = 1'b1; m_werr++; end
        if (m_werr == BL) begin
          m_state = 0; m_lost = 1'b1; m_phase = 0; m_werr = 0; hist.delete();
        end else begin
          if (m_phase == 31) m_werr = 0;
          m_phase = (m_phase + 1) % 32;
        end
      end
    end
    if (c) m_errc = err ? 1 : 0;
    else if (err && m_errc < 65535) m_errc++;
    m_pulse = err;
  endfunction

  task automatic step(input bit b, input bit v, input bit c);
    bus.bit_in = b; bus.bit_valid = v; bus.clr_err = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0; bus.bit_valid = 1'b1; bus.clr_err = 1'b1; bus.bit_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1; bus.bit_valid = 1'b0; bus.clr_err = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.state !== 2'd0)      begin miscompares++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    vectors++; if (bus.locked !== 1'b0)     begin miscompares++; $display("FAIL reset_locked got=%b want=0", bus.locked); end
    vectors++; if (bus.bit_phase !== 5'd0)  begin miscompares++; $display("FAIL reset_phase got=%0d want=0", bus.bit_phase); end
    vectors++; if (bus.err_count !== 16'd0) begin miscompares++; $display("FAIL reset_errcnt got=%0d want=0", bus.err_count); end
    vectors++; if (bus.err_pulse !== 1'b0)  begin miscompares++; $display("FAIL reset_pulse got=%b want=0", bus.err_pulse); end
    vectors++; if (bus.lock_lost !== 1'b0)  begin miscompares++; $display("FAIL reset_lost got=%b want=0", bus.lock_lost); end
  endtask

  task automatic test_clean_lock();
    int first_ver = -1;
    int first_lock = -1;
    apply_reset();
    for (int n = 1; n <= 192; n++) begin
      step(pat_bit(n - 1), 1'b1, 1'b0);
      if (first_ver < 0 && bus.state === 2'd1) first_ver = n;
      if (first_lock < 0 && bus.locked === 1'b1) first_lock = n;
      vectors++;
      if (bus.state !== 2'(m_state) || bus.bit_phase !== 5'(m_phase)) begin
        miscompares++;
        $display("FAIL clean_track n=%0d state=%0d want=%0d phase=%0d want=%0d", n, bus.state, m_state, bus.bit_phase, m_phase);
      end
    end
    vectors++; if (first_ver != 32)   begin miscompares++; $display("FAIL clean_verify_at got=%0d want=32", first_ver); end
    vectors++; if (first_lock != 160) begin miscompares++; $display("FAIL clean_lock_at got=%0d want=160", first_lock); end
    vectors++; if (bus.err_count !== 16'd0) begin miscompares++; $display("FAIL clean_errcnt got=%0d want=0", bus.err_count); end
  endtask

  task automatic test_sparse_errors();
    int pulses = 0;
    int drops = 0;
    int base;
    int pos;
    base = m_errc;
    for (int k = 0; k < 10; k++) begin
      pos = $urandom_range(0, 63);
      for (int j = 0; j < 64; j++) begin
        step(pat_bit(j) ^ (j == pos), 1'b1, 1'b0);
        if (bus.err_pulse === 1'b1) pulses++;
        if (bus.locked !== 1'b1) drops++;
        vectors++;
        if (bus.err_pulse !== (j == pos)) begin
          miscompares++;
          $display("FAIL sparse_pulse k=%0d j=%0d got=%b want=%b", k, j, bus.err_pulse, j == pos);
        end
      end
    end
    vectors++; if (pulses != 10) begin miscompares++; $display("FAIL sparse_pulses got=%0d want=10", pulses); end
    vectors++; if (bus.err_count !== 16'(base + 10)) begin miscompares++; $display("FAIL sparse_errcnt got=%0d want=%0d", bus.err_count, base + 10); end
    vectors++; if (drops != 0) begin miscompares++; $display("FAIL sparse_locked drops=%0d want=0", drops); end
  endtask

  task automatic test_lock_loss();
    logic [31:0] mask = 32'h8000_0000;
    int lost_at = -1;
    int first_lock = -1;
    int errc0;
    while ($countones(mask) < BL) mask = mask | (32'd1 << $urandom_range(0, 30));
    errc0 = m_errc;
    for (int j = 0; j < 32; j++) begin
      step(pat_bit(j) ^ 1'(mask >> j), 1'b1, 1'b0);
      if (lost_at < 0 && bus.lock_lost === 1'b1) lost_at = j;
      vectors++;
      if (bus.locked !== (j != 31)) begin miscompares++; $display("FAIL loss_locked j=%0d got=%b want=%b", j, bus.locked, j != 31); end
    end
    vectors++; if (lost_at != 31) begin miscompares++; $display("FAIL loss_strobe_at got=%0d want=31", lost_at); end
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL loss_state got=%0d want=0", bus.state); end
    vectors++; if (bus.err_count !== 16'(errc0 + BL)) begin miscompares++; $display("FAIL loss_errcnt got=%0d want=%0d", bus.err_count, errc0 + BL); end
    for (int n = 1; n <= 192; n++) begin
      step(pat_bit(n - 1), 1'b1, 1'b0);
      if (n == 1) begin
        vectors++;
        if (bus.lock_lost !== 1'b0) begin miscompares++; $display("FAIL loss_strobe_len got=%b want=0", bus.lock_lost); end
      end
      if (first_lock < 0 && bus.locked === 1'b1) first_lock = n;
    end
    vectors++; if (first_lock != 160) begin miscompares++; $display("FAIL relock_at got=%0d want=160", first_lock); end
  endtask

  task automatic test_verify_error();
    int saved;
    int p;
    int pulses = 0;
    for (int j = 0; j < 32; j++) step(pat_bit(j) ^ (j >= 24), 1'b1, 1'b0);
    saved = m_errc;
    for (int j = 0; j < 32; j++) step(pat_bit(j), 1'b1, 1'b0);
    vectors++; if (bus.state !== 2'd1) begin miscompares++; $display("FAIL verr_enter got=%0d want=1", bus.state); end
    for (int j = 0; j < 64; j++) step(pat_bit(j), 1'b1, 1'b0);
    vectors++; if (bus.state !== 2'd1) begin miscompares++; $display("FAIL verr_word2 got=%0d want=1", bus.state); end
    p = $urandom_range(0, 31);
    for (int j = 0; j <= p; j++) begin
      step(pat_bit(j) ^ (j == p), 1'b1, 1'b0);
      if (bus.err_pulse === 1'b1) pulses++;
    end
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL verr_hunt got=%0d want=0", bus.state); end
    vectors++; if (bus.err_count !== 16'(saved)) begin miscompares++; $display("FAIL verr_errcnt got=%0d want=%0d", bus.err_count, saved); end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL verr_pulse got=%0d want=0", pulses); end
  endtask

  task automatic test_clr_err();
    int k;
    apply_reset();
    for (int n = 0; n < 160; n++) step(pat_bit(n), 1'b1, 1'b0);
    vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL clr_lock got=%b want=1", bus.locked); end
    for (int j = 0; j < 32; j++) step(pat_bit(j) ^ (j == 2 || j == 9 || j == 20), 1'b1, 1'b0);
    vectors++; if (bus.err_count !== 16'd3) begin miscompares++; $display("FAIL clr_pre got=%0d want=3", bus.err_count); end
    k = $urandom_range(0, 31);
    for (int j = 0; j < 32; j++) begin
      step(pat_bit(j) ^ (j == k), 1'b1, j == k);
      if (j == k) begin
        vectors++;
        if (bus.err_count !== 16'd1) begin miscompares++; $display("FAIL clr_with_err got=%0d want=1", bus.err_count); end
      end
    end
    step(1'b0, 1'b0, 1'b1);
    vectors++; if (bus.err_count !== 16'd0) begin miscompares++; $display("FAIL clr_alone got=%0d want=0", bus.err_count); end
    vectors++; if (bus.state !== 2'd2 || bus.bit_phase !== 5'd0) begin miscompares++; $display("FAIL clr_idle state=%0d phase=%0d want=2/0", bus.state, bus.bit_phase); end
  endtask

  task automatic test_offset();
    int first_ver = -1;
    int first_lock = -1;
    apply_reset();
    for (int n = 1; n <= 224; n++) begin
      step(pat_bit(13 + n - 1), 1'b1, 1'b0);
      if (first_ver < 0 && bus.state === 2'd1) first_ver = n;
      if (first_lock < 0 && bus.locked === 1'b1) first_lock = n;
      if (n > 51) begin
        vectors++;
        if (bus.bit_phase !== 5'((13 + n) % 32)) begin miscompares++; $display("FAIL offset_phase n=%0d got=%0d want=%0d", n, bus.bit_phase, (13 + n) % 32); end
      end
    end
    vectors++; if (first_ver != 51)   begin miscompares++; $display("FAIL offset_verify_at got=%0d want=51", first_ver); end
    vectors++; if (first_lock != 179) begin miscompares++; $display("FAIL offset_lock_at got=%0d want=179", first_lock); end
  endtask

  task automatic test_valid_toggle();
    int nv = 0;
    int first_lock = -1;
    bit lock_on_idle = 1'b0;
    bit v;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = (cyc % 2) == 0;
      if (v) nv++;
      step(v ? pat_bit(nv - 1) : 1'($urandom_range(0, 1)), v, 1'b0);
      if (first_lock < 0 && bus.locked === 1'b1) begin first_lock = nv; lock_on_idle = !v; end
      vectors++;
      if (bus.state !== 2'(m_state) || bus.bit_phase !== 5'(m_phase)) begin
        miscompares++;
        $display("FAIL toggle_track cyc=%0d state=%0d want=%0d phase=%0d want=%0d", cyc, bus.state, m_state, bus.bit_phase, m_phase);
      end
    end
    vectors++; if (first_lock != 160) begin miscompares++; $display("FAIL toggle_lock_at got=%0d want=160", first_lock); end
    vectors++; if (lock_on_idle) begin miscompares++; $display("FAIL toggle_idle_change got=1 want=0"); end
  endtask

  task automatic test_random();
    int idx;
    int burst = 0;
    bit v, c, e;
    apply_reset();
    idx = $urandom_range(0, 31);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 79) == 0;
      if (burst == 0 && $urandom_range(0, 399) == 0) burst = 24;
      e = (burst > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 249) == 0);
      if (v && $urandom_range(0, 1999) == 0) idx++;
      step(pat_bit(idx) ^ e, v, c);
      if (v) begin idx = (idx + 1) % 32; if (burst > 0) burst--; end
      vectors++;
      if ({bus.state, bus.locked, bus.bit_phase, bus.err_pulse, bus.lock_lost, bus.err_count} !==
          {2'(m_state), (m_state == 2), 5'(m_phase), m_pulse, m_lost, 16'(m_errc)}) begin
        miscompares++;
        $display("FAIL random cyc=%0d st=%0d/%0d ph=%0d/%0d pulse=%b/%b lost=%b/%b cnt=%0d/%0d", cyc,
                 bus.state, m_state, bus.bit_phase, m_phase, bus.err_pulse, m_pulse, bus.lock_lost, m_lost, bus.err_count, m_errc);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    for (int n = 0; n < 170; n++) step(pat_bit(n) ^ (n == 165), 1'b1, 1'b0);
    vectors++; if (bus.locked !== 1'b1 || bus.err_count !== 16'd1) begin miscompares++; $display("FAIL midrst_pre locked=%b cnt=%0d want=1/1", bus.locked, bus.err_count); end
    aresetn = 1'b0; bus.bit_valid = 1'b1; bus.bit_in = ~pat_bit(170); bus.clr_err = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.lock_lost !== 1'b0) begin miscompares++; $display("FAIL midrst_lost got=%b want=0", bus.lock_lost); end
    vectors++; if (bus.state !== 2'd0 || bus.locked !== 1'b0 || bus.bit_phase !== 5'd0) begin miscompares++; $display("FAIL midrst_state st=%0d lk=%b ph=%0d want=0/0/0", bus.state, bus.locked, bus.bit_phase); end
    vectors++; if (bus.err_count !== 16'd0 || bus.err_pulse !== 1'b0) begin miscompares++; $display("FAIL midrst_err cnt=%0d pulse=%b want=0/0", bus.err_count, bus.err_pulse); end
    aresetn = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lock_lost !== 1'b0) begin miscompares++; $display("FAIL midrst_after got=%b want=0", bus.lock_lost); end
  endtask

  initial begin
    aresetn = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.clr_err = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_sparse_errors();
    test_lock_loss();
    test_verify_error();
    test_clr_err();
    test_offset();
    test_valid_toggle();
    test_random();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
